// File: rtl/game_pkg.sv
// Shared game-level types and constants.
//   spawn_entry_t   : one spawn-table word {col[7:0], y[9:0]}
//   spawner_state_e : goomba_spawner FSM states
//   END_COL         : column value that terminates the spawn table
//   TILE_W          : width in pixels of one world column
package game_pkg;

  localparam logic [7:0] END_COL = 8'hFF;
  localparam int         TILE_W  = 40;

  typedef struct packed {
    logic [7:0] col;
    logic [9:0] y;
  } spawn_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_WAIT,
    ST_CHECK,
    ST_SPAWN,
    ST_DONE
  } spawner_state_e;

endpackage

// File: rtl/goomba_spawner_slot_alloc.sv
// slot_alloc: picks the lowest-index goomba slot that is neither alive nor
// reserved (recently started, still inside the goomba's register latency).
// Ports:
//   is_alive  in  N_SLOTS  isAlive_out of each slot
//   reserved  in  N_SLOTS  slots started in the last two clocks
//   grant     out N_SLOTS  one-hot lowest free slot (zero if none)
//   any_free  out 1        at least one slot is free
module slot_alloc
  import game_pkg::*;
#(
  parameter int N_SLOTS = 4
) (
  input  logic [N_SLOTS-1:0] is_alive,
  input  logic [N_SLOTS-1:0] reserved,
  output logic [N_SLOTS-1:0] grant,
  output logic               any_free
);

  logic [N_SLOTS-1:0] free;

  always_comb begin
    free  = ~is_alive & ~reserved;
    grant = '0;
    // Scan from the top so the last hit, the lowest index, wins.
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    any_free = |free;
  end

endmodule

// File: rtl/goomba_spawner.sv
// goomba_spawner: level-side driver of the goomba start/kill interface.
// Walks a column-sorted spawn table in ROM as the screen scrolls and issues
// one-cycle start pulses (with spawnX/spawnY) to free goomba slots. Kills
// every slot when a level starts.
// Ports:
//   Clk, Reset   clock and synchronous active-high reset
//   frame_clk    frame strobe, asynchronous, rising edge detected here
//   Shift        screen scrolled one column this frame (sampled on frame edge)
//   level_start  one-cycle pulse: reload level, clear all enemies
//   isAlive      isAlive_out of each goomba slot
//   rom_addr     spawn-table address; rom_data is valid one clock later
//   rom_data     {col[17:10], spawnY[9:0]}
//   start        one-hot one-clock spawn pulse
//   kill         one-clock kill pulse, all slots
//   spawnX/Y     spawn position, held until the next spawn
//   scroll_col   current leftmost world column
//   done         spawn table exhausted
module goomba_spawner
  import game_pkg::*;
#(
  parameter int         N_SLOTS  = 4,
  parameter int         ROM_AW   = 6,
  parameter logic [7:0] VIS_COLS = 8'd10,
  parameter logic [9:0] SPAWN_X  = 10'd500,
  parameter logic [7:0] END_COL  = game_pkg::END_COL
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               Shift,
  input  logic               level_start,
  input  logic [N_SLOTS-1:0] isAlive,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [17:0]        rom_data,
  output logic [N_SLOTS-1:0] start,
  output logic [N_SLOTS-1:0] kill,
  output logic [9:0]         spawnX,
  output logic [9:0]         spawnY,
  output logic [7:0]         scroll_col,
  output logic               done
);

  spawner_state_e     state_q, state_d;
  logic               frame_clk_delayed_q, frame_clk_delayed_d;
  logic               fe_q, fe_d;
  logic [7:0]         scroll_col_q, scroll_col_d;
  logic [ROM_AW-1:0]  ptr_q, ptr_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  spawn_entry_t       entry_q, entry_d;
  logic [9:0]         spawnx_q, spawnx_d;
  logic [9:0]         spawny_q, spawny_d;
  logic               done_q, done_d;
  logic [N_SLOTS-1:0] res1_q, res1_d;
  logic [N_SLOTS-1:0] res2_q, res2_d;
  logic [N_SLOTS-1:0] start_o, kill_o;
  logic [N_SLOTS-1:0] grant;
  logic               any_free;
  logic               in_view;

  slot_alloc #(
    .N_SLOTS (N_SLOTS)
  ) u_slot_alloc (
    .is_alive (isAlive),
    .reserved (res1_q | res2_q),
    .grant    (grant),
    .any_free (any_free)
  );

  // Widened by one bit so a scroll near the top of the range cannot wrap.
  assign in_view = ({1'b0, entry_q.col} <= ({1'b0, scroll_col_q} + {1'b0, VIS_COLS}));

  always_comb begin
    state_d             = state_q;
    frame_clk_delayed_d = frame_clk;
    fe_d                = frame_clk & ~frame_clk_delayed_q;
    scroll_col_d        = scroll_col_q;
    ptr_d               = ptr_q;
    entry_d             = entry_q;
    spawnx_d            = spawnx_q;
    spawny_d            = spawny_q;
    done_d              = done_q;
    start_o             = '0;
    kill_o              = '0;

    if (fe_q && Shift && state_q != ST_IDLE && state_q != ST_CLEAR &&
        scroll_col_q < 8'hFE) begin
      scroll_col_d = scroll_col_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: ;
      ST_CLEAR: begin
        kill_o       = '1;
        ptr_d        = '0;
        scroll_col_d = '0;
        done_d       = 1'b0;
        state_d      = ST_FETCH;
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        entry_d = spawn_entry_t'(rom_data);
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (entry_q.col == END_COL) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (entry_q.col < scroll_col_q) begin
          ptr_d   = ptr_q + ROM_AW'(1);
          state_d = ST_FETCH;
        end else if (in_view && any_free) begin
          state_d = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        // A slot can vanish between CHECK and SPAWN only if isAlive moved;
        // fall back to CHECK rather than pulse nothing and lose the entry.
        if (any_free) begin
          start_o  = grant;
          spawnx_d = SPAWN_X;
          spawny_d = entry_q.y;
          ptr_d    = ptr_q + ROM_AW'(1);
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    // level_start overrides everything, including a spawn in flight.
    if (level_start) begin
      state_d  = ST_CLEAR;
      start_o  = '0;
      spawnx_d = spawnx_q;
      spawny_d = spawny_q;
    end

    // The address tracks the pointer every cycle, so a registered ROM has
    // already sampled it by the end of FETCH and its data is stable in WAIT.
    rom_addr_d = ptr_d;
    res1_d     = start_o;
    res2_d     = res1_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q             <= ST_IDLE;
      frame_clk_delayed_q <= 1'b0;
      fe_q                <= 1'b0;
      scroll_col_q        <= '0;
      ptr_q               <= '0;
      rom_addr_q          <= '0;
      spawnx_q            <= '0;
      spawny_q            <= '0;
      done_q              <= 1'b0;
      res1_q              <= '0;
      res2_q              <= '0;
    end else begin
      state_q             <= state_d;
      frame_clk_delayed_q <= frame_clk_delayed_d;
      fe_q                <= fe_d;
      scroll_col_q        <= scroll_col_d;
      ptr_q               <= ptr_d;
      rom_addr_q          <= rom_addr_d;
      spawnx_q            <= spawnx_d;
      spawny_q            <= spawny_d;
      done_q              <= done_d;
      res1_q              <= res1_d;
      res2_q              <= res2_d;
    end
  end

  // The entry register is always loaded in WAIT before CHECK reads it.
  always_ff @(posedge Clk) begin
    entry_q <= entry_d;
  end

  assign rom_addr   = rom_addr_q;
  assign start      = start_o;
  assign kill       = kill_o;
  assign spawnX     = spawnx_q;
  assign spawnY     = spawny_q;
  assign scroll_col = scroll_col_q;
  assign done       = done_q;

endmodule

// File: tb/tb_goomba_spawner.sv
module tb_goomba_spawner;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        Shift = 1'b0;
  logic        level_start = 1'b0;
  logic [3:0]  isAlive = 4'b0000;
  logic [5:0]  rom_addr;
  logic [17:0] rom_data = '0;
  logic [3:0]  start;
  logic [3:0]  kill;
  logic [9:0]  spawnX;
  logic [9:0]  spawnY;
  logic [7:0]  scroll_col;
  logic        done;

  logic [17:0] rom [64];

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  goomba_spawner dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .Shift       (Shift),
    .level_start (level_start),
    .isAlive     (isAlive),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .start       (start),
    .kill        (kill),
    .spawnX      (spawnX),
    .spawnY      (spawnY),
    .scroll_col  (scroll_col),
    .done        (done)
  );

  always #5 Clk = ~Clk;

  // Registered ROM: data valid one clock after the address.
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count start pulses and check the one-hot / no start+kill invariants.
  always @(negedge Clk) begin
    if (!Reset && (|start || |kill)) begin
      n_checks++;
      if ($countones(start) > 1 || (start & kill) != 4'b0000) begin
        n_fail++;
        $display("FAIL invariant: start %b kill %b", start, kill);
      end
    end
    if (|start) start_cnt++;
  end

  task automatic do_reset();
    Reset = 1'b1; level_start = 1'b0; isAlive = 4'b0000;
    Shift = 1'b0; frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = {8'hFF, 10'd0};
  endtask

  task automatic pulse_level();
    level_start = 1'b1;
    @(posedge Clk);
    #1 level_start = 1'b0;
  endtask

  task automatic frame(input logic sh);
    Shift = sh; frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Shift = 1'b0;
  endtask

  // Waits up to n edges for a start pulse; returns 1 if seen.
  task automatic wait_start(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (start != 4'b0000) begin
        seen = 1'b1;
        break;
      end
      @(posedge Clk);
      #1;
    end
    if (start != 4'b0000) seen = 1'b1;
  endtask

  typedef struct {
    logic [7:0] col;
    logic [9:0] y;
    logic [3:0] alive;
    logic [3:0] exp_start;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic seen;
    int   base;

    vecs[0] = '{col: 8'd3,  y: 10'd200,  alive: 4'b0000, exp_start: 4'b0001};
    vecs[1] = '{col: 8'd0,  y: 10'd50,   alive: 4'b0001, exp_start: 4'b0010};
    vecs[2] = '{col: 8'd10, y: 10'd399,  alive: 4'b0011, exp_start: 4'b0100};
    vecs[3] = '{col: 8'd7,  y: 10'd1023, alive: 4'b0111, exp_start: 4'b1000};
    vecs[4] = '{col: 8'd5,  y: 10'd0,    alive: 4'b1010, exp_start: 4'b0001};
    vecs[5] = '{col: 8'd1,  y: 10'd123,  alive: 4'b1101, exp_start: 4'b0010};
    vecs[6] = '{col: 8'd11, y: 10'd321,  alive: 4'b0000, exp_start: 4'b0000};

    clear_rom();
    do_reset();
    chk("reset start", 32'(start), 32'h0);
    chk("reset kill", 32'(kill), 32'h0);
    chk("reset spawnX", 32'(spawnX), 32'h0);
    chk("reset spawnY", 32'(spawnY), 32'h0);
    chk("reset rom_addr", 32'(rom_addr), 32'h0);
    chk("reset scroll_col", 32'(scroll_col), 32'h0);
    chk("reset done", 32'(done), 32'h0);

    // Reset wins over a simultaneous level_start.
    Reset = 1'b1; level_start = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0; level_start = 1'b0;
    chk("reset prio kill", 32'(kill), 32'h0);
    @(posedge Clk); #1;
    chk("reset prio kill later", 32'(kill), 32'h0);

    // Single-entry spawn table vectors.
    for (int r = 0; r < 7; r++) begin
      do_reset();
      clear_rom();
      rom[0] = {vecs[r].col, vecs[r].y};
      isAlive = vecs[r].alive;
      pulse_level();
      chk($sformatf("v%0d kill", r), 32'(kill), 32'hF);
      wait_start(8, seen);
      chk($sformatf("v%0d start", r), 32'(start), 32'(vecs[r].exp_start));
      if (vecs[r].exp_start != 4'b0000) begin
        @(posedge Clk); #1;
        chk($sformatf("v%0d spawnX", r), 32'(spawnX), 32'd500);
        chk($sformatf("v%0d spawnY", r), 32'(spawnY), 32'(vecs[r].y));
      end
      repeat (6) @(posedge Clk);
      #1;
      chk($sformatf("v%0d done", r), 32'(done), 32'(vecs[r].exp_start != 4'b0000));
    end

    // Entry at col 15 waits until scroll_col reaches 5.
    do_reset(); clear_rom();
    rom[0] = {8'd15, 10'd300};
    pulse_level();
    repeat (10) @(posedge Clk);
    #1 base = start_cnt;
    for (int f = 0; f < 4; f++) frame(1'b1);
    chk("t2 scroll4", 32'(scroll_col), 32'd4);
    chk("t2 no early start", 32'(start_cnt - base), 32'd0);
    frame(1'b1);
    chk("t2 scroll5", 32'(scroll_col), 32'd5);
    chk("t2 spawn after 5", 32'(start_cnt - base), 32'd1);
    chk("t2 spawnY", 32'(spawnY), 32'd300);

    // All slots alive: hold in CHECK until slot 2 frees.
    do_reset(); clear_rom();
    rom[0] = {8'd2, 10'd77};
    isAlive = 4'b1111;
    pulse_level();
    base = start_cnt;
    repeat (12) @(posedge Clk);
    #1;
    chk("t3 blocked", 32'(start_cnt - base), 32'd0);
    isAlive = 4'b1011;
    wait_start(3, seen);
    chk("t3 seen", 32'(seen), 32'd1);
    chk("t3 start", 32'(start), 32'b0100);

    // Entry behind the scroll is skipped.
    do_reset(); clear_rom();
    rom[0] = {8'd16, 10'd100};
    rom[1] = {8'd2,  10'd11};
    rom[2] = {8'd8,  10'd222};
    pulse_level();
    base = start_cnt;
    for (int f = 0; f < 5; f++) frame(1'b1);
    chk("t4 none at 5", 32'(start_cnt - base), 32'd0);
    frame(1'b1);
    repeat (30) @(posedge Clk);
    #1;
    chk("t4 scroll", 32'(scroll_col), 32'd6);
    chk("t4 two spawns", 32'(start_cnt - base), 32'd2);
    chk("t4 spawnY", 32'(spawnY), 32'd222);
    chk("t4 rom_addr", 32'(rom_addr), 32'd3);
    chk("t4 done", 32'(done), 32'd1);

    // level_start in the same cycle as SPAWN.
    do_reset(); clear_rom();
    rom[0] = {8'd12, 10'd200};
    pulse_level();
    repeat (8) @(posedge Clk);
    #1;
    frame(1'b1);
    Shift = 1'b1; frame_clk = 1'b1;
    wait_start(8, seen);
    chk("t5 spawn reached", 32'(start), 32'b0001);
    chk("t5 scroll before", 32'(scroll_col), 32'd2);
    level_start = 1'b1;
    #1;
    chk("t5 start suppressed", 32'(start), 32'h0);
    base = start_cnt;
    @(posedge Clk);
    #1 level_start = 1'b0; Shift = 1'b0; frame_clk = 1'b0;
    chk("t5 kill", 32'(kill), 32'hF);
    chk("t5 start in clear", 32'(start), 32'h0);
    @(posedge Clk); #1;
    chk("t5 scroll cleared", 32'(scroll_col), 32'd0);
    chk("t5 spawnY held", 32'(spawnY), 32'd0);
    repeat (10) @(posedge Clk);
    #1;
    chk("t5 rom_addr restart", 32'(rom_addr), 32'd0);
    chk("t5 no spawn", 32'(start_cnt - base), 32'd0);
    frame(1'b1);
    frame(1'b1);
    chk("t5 respawn", 32'(start_cnt - base), 32'd1);
    chk("t5 respawn Y", 32'(spawnY), 32'd200);

    // Scroll needs a frame edge, and saturates at 0xFE.
    do_reset(); clear_rom();
    pulse_level();
    repeat (8) @(posedge Clk);
    #1;
    chk("t6 done", 32'(done), 32'd1);
    Shift = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    chk("t6 no fe", 32'(scroll_col), 32'd0);
    frame_clk = 1'b1;
    repeat (20) @(posedge Clk);
    #1 frame_clk = 1'b0; Shift = 1'b0;
    chk("t6 single edge", 32'(scroll_col), 32'd1);
    frame(1'b0);
    chk("t6 no shift", 32'(scroll_col), 32'd1);
    for (int f = 0; f < 300; f++) frame(1'b1);
    chk("t6 saturate", 32'(scroll_col), 32'hFE);
    chk("t6 still done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
